// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and helpers for the 4-source round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set request after 'last',
// optionally skipping one excluded source (the current owner on preemption).
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] last,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from lowest to highest priority so the last hit written wins;
  // offset N_SRC wraps back onto 'last' itself, the lowest priority slot.
  always_comb begin
    any  = 1'b0;
    idx  = last;
    cand = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand] && !(excl_en && (cand == excl))) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit select among four requesters,
// with a bounded hold time and a registered copy of the selected data bit.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] din,
  output logic [N_SRC-1:0] gnt,
  output logic             s1,
  output logic             s0,
  output logic             y,
  output logic             y_vld
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t       state;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] sel;
  logic [HOLD_W-1:0] hold_cnt;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             at_max;

  // While granted, 'last' is the owner; excluding it makes pick_any mean
  // "someone else is waiting", which serves both release and preemption.
  rr_pick4 u_pick (
    .req     (req),
    .last    (last),
    .excl_en (state == GRANT),
    .excl    (last),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  assign owner_req = req[last];
  assign at_max    = (hold_cnt == HOLD_W'(MAX_HOLD));
  assign s1        = sel[1];
  assign s0        = sel[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= SEL_W'(N_SRC - 1);
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      y        <= 1'b0;
      y_vld    <= 1'b0;
    end else begin
      y_vld <= |gnt;
      if (|gnt) y <= din[sel];

      if (state == IDLE) begin
        if (pick_any) begin
          gnt      <= onehot(pick_idx);
          sel      <= pick_idx;
          last     <= pick_idx;
          hold_cnt <= HOLD_W'(1);
          state    <= GRANT;
        end
      end else if (!owner_req) begin
        if (pick_any) begin
          gnt      <= onehot(pick_idx);
          sel      <= pick_idx;
          last     <= pick_idx;
          hold_cnt <= HOLD_W'(1);
        end else begin
          gnt      <= '0;
          hold_cnt <= '0;
          state    <= IDLE;
        end
      end else if (at_max && pick_any) begin
        gnt      <= onehot(pick_idx);
        sel      <= pick_idx;
        last     <= pick_idx;
        hold_cnt <= HOLD_W'(1);
      end else if (!at_max) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized bench for mux4_rr_arbiter against an integer-level
// model of the rotating-priority, bounded-hold arbitration rules.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       y;
  logic       y_vld;

  int vectors;
  int miscompares;

  // Reference model: owner is -1 when nothing is granted.
  int   m_owner;
  int   m_last;
  int   m_hold;
  int   m_sel;
  logic m_y;
  logic m_vld;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .y     (y),
    .y_vld (y_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick_from(input logic [3:0] r, input int start, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_hold  = 0;
    m_sel   = 0;
    m_y     = 1'b0;
    m_vld   = 1'b0;
  endtask

  task automatic model_grant(input int p);
    m_owner = p;
    m_last  = p;
    m_sel   = p;
    m_hold  = 1;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    int p;
    if (m_owner >= 0) m_y = d[m_sel];
    m_vld = (m_owner >= 0);
    if (m_owner < 0) begin
      p = pick_from(r, m_last, -1);
      if (p >= 0) model_grant(p);
    end else if (!r[m_owner]) begin
      p = pick_from(r, m_owner, -1);
      if (p >= 0) model_grant(p);
      else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else begin
      p = pick_from(r, m_owner, m_owner);
      if (m_hold == MAX_HOLD && p >= 0) model_grant(p);
      else if (m_hold < MAX_HOLD) m_hold = m_hold + 1;
    end
  endtask

  task automatic check_output(input string tag);
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    exp_sel = 2'(m_sel);
    vectors++;
    assert (gnt === exp_gnt) else begin
      miscompares++;
      $error("FAIL %s gnt: observed %b expected %b", tag, gnt, exp_gnt);
    end
    vectors++;
    assert ({s1, s0} === exp_sel) else begin
      miscompares++;
      $error("FAIL %s sel: observed %b expected %b", tag, {s1, s0}, exp_sel);
    end
    vectors++;
    assert (y_vld === m_vld) else begin
      miscompares++;
      $error("FAIL %s y_vld: observed %b expected %b", tag, y_vld, m_vld);
    end
    vectors++;
    assert (y === m_y) else begin
      miscompares++;
      $error("FAIL %s y: observed %b expected %b", tag, y, m_y);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] d, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = r;
      din = d;
      model_step(r, d);
      @(posedge clk);
      #1;
      check_output(tag);
    end
  endtask

  initial begin
    logic [3:0] rnd_req;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req         = 4'b0000;
    din         = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    check_output("reset");
    rst_n = 1'b1;

    apply_stimulus(4'b1111, 4'b0110, 17, "all_req_rotate");
    apply_stimulus(4'b0000, 4'b0000, 2, "drain1");
    apply_stimulus(4'b0100, 4'b1011, 10, "single_req_hold");
    apply_stimulus(4'b0000, 4'b0000, 2, "drain2");
    apply_stimulus(4'b0010, 4'b0000, 2, "owner1");
    apply_stimulus(4'b1000, 4'b0000, 2, "release_to3");
    apply_stimulus(4'b0000, 4'b1010, 2, "drain3");
    apply_stimulus(4'b0010, 4'b1010, 2, "din_src1");
    apply_stimulus(4'b0100, 4'b1010, 3, "din_src2");
    apply_stimulus(4'b0000, 4'b0000, 3, "all_drop");
    apply_stimulus(4'b0011, 4'b0101, 2, "pre_reset");

    // Asynchronous reset pulse between clock edges while a grant is active.
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    #1;
    check_output("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'b1001, 4'b1111, 2, "post_reset");

    rnd_req = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) rnd_req = 4'($urandom_range(15));
      apply_stimulus(rnd_req, 4'($urandom_range(15)), 1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
